// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter.
// Shares the single regfile write port between the ALU writeback path and the
// multiply/divide unit. The md result sits in a one-entry buffer; the ALU has
// priority, but a wait counter caps how many ALU grants the buffered result
// can lose before it is forced through. The winning write is registered onto
// the write port together with a one-hot per-register enable vector.
module regfile_write_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 3
) (
  input  logic        clock,
  input  logic        ctrl_reset_n,

  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  output logic        alu_ready,

  input  logic        md_valid,
  input  logic [4:0]  md_rd,
  input  logic [31:0] md_data,
  output logic        md_ready,

  output logic        ctrl_writeEnable,
  output logic [4:0]  ctrl_writeReg,
  output logic [31:0] data_writeReg,
  output logic [31:0] we_onehot,
  output logic        md_pending
);

  localparam logic [CNT_W-1:0] StarveLimitCnt = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] CntMax         = {CNT_W{1'b1}};

  // md result buffer
  logic             buf_full_q, buf_full_d;
  logic [4:0]       buf_rd_q, buf_rd_d;
  logic [31:0]      buf_data_q, buf_data_d;

  // ALU grants lost by the buffered result since it was loaded
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  // Registered write port
  logic             write_enable_q, write_enable_d;
  logic [4:0]       write_reg_q, write_reg_d;
  logic [31:0]      write_data_q, write_data_d;
  logic [31:0]      we_onehot_q, we_onehot_d;

  // Arbitration terms
  logic             force_md;
  logic             drain;
  logic             alu_grant;
  logic             md_load;
  logic             win_valid;
  logic [4:0]       win_rd;
  logic [31:0]      win_data;
  logic             win_we;

  // Arbitration: ALU first unless the buffered md result has waited too long
  always_comb begin
    force_md  = buf_full_q && (wait_cnt_q >= StarveLimitCnt);
    alu_ready = !force_md;
    drain     = buf_full_q && (force_md || !alu_valid);
    alu_grant = alu_valid && alu_ready;
    // A draining buffer can take a new result in the same cycle
    md_ready  = !buf_full_q || drain;
    md_load   = md_valid && md_ready;

    win_valid = alu_grant || drain;
    win_rd    = alu_grant ? alu_rd   : buf_rd_q;
    win_data  = alu_grant ? alu_data : buf_data_q;
    // Writes to x0 complete the handshake but never reach the regfile
    win_we    = win_valid && (win_rd != 5'd0);
  end

  // Buffer and starvation-counter next state
  always_comb begin
    buf_full_d = buf_full_q;
    buf_rd_d   = buf_rd_q;
    buf_data_d = buf_data_q;
    wait_cnt_d = wait_cnt_q;

    if (drain) begin
      buf_full_d = 1'b0;
    end
    if (md_load) begin
      buf_full_d = 1'b1;
      buf_rd_d   = md_rd;
      buf_data_d = md_data;
    end

    if (drain || !buf_full_q) begin
      wait_cnt_d = '0;
    end else if (alu_grant && (wait_cnt_q != CntMax)) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  // Write-port next state; reg/data hold their last value when nothing wins
  always_comb begin
    write_enable_d = win_we;
    write_reg_d    = write_reg_q;
    write_data_d   = write_data_q;
    we_onehot_d    = '0;

    if (win_valid) begin
      write_reg_d  = win_rd;
      write_data_d = win_data;
    end
    if (win_we) begin
      we_onehot_d = 32'd1 << win_rd;
    end
  end

  // Buffer and counter state
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      buf_full_q <= 1'b0;
      buf_rd_q   <= '0;
      buf_data_q <= '0;
      wait_cnt_q <= '0;
    end else begin
      buf_full_q <= buf_full_d;
      buf_rd_q   <= buf_rd_d;
      buf_data_q <= buf_data_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Registered write port
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      write_enable_q <= 1'b0;
      write_reg_q    <= '0;
      write_data_q   <= '0;
      we_onehot_q    <= '0;
    end else begin
      write_enable_q <= write_enable_d;
      write_reg_q    <= write_reg_d;
      write_data_q   <= write_data_d;
      we_onehot_q    <= we_onehot_d;
    end
  end

  assign ctrl_writeEnable = write_enable_q;
  assign ctrl_writeReg    = write_reg_q;
  assign data_writeReg    = write_data_q;
  assign we_onehot        = we_onehot_q;
  assign md_pending       = buf_full_q;

  // The one-hot vector must agree with the scalar write port
  always_ff @(posedge clock) begin
    if (ctrl_reset_n) begin
      assert ($onehot0(we_onehot_q));
      assert (!write_enable_q || (we_onehot_q == (32'd1 << write_reg_q)));
      assert (write_enable_q || (we_onehot_q == '0));
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: directed scenarios followed by
// random traffic, with expected writes queued by a reference model and popped
// by an independent monitor whenever the write port is enabled.
module tb_regfile_write_arbiter;

  localparam int unsigned STARVE_LIMIT = 4;

  logic        clock;
  logic        ctrl_reset_n;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        md_valid;
  logic [4:0]  md_rd;
  logic [31:0] md_data;
  logic        md_ready;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic [31:0] we_onehot;
  logic        md_pending;

  regfile_write_arbiter #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .CNT_W        (3)
  ) dut (
    .clock            (clock),
    .ctrl_reset_n     (ctrl_reset_n),
    .alu_valid        (alu_valid),
    .alu_rd           (alu_rd),
    .alu_data         (alu_data),
    .alu_ready        (alu_ready),
    .md_valid         (md_valid),
    .md_rd            (md_rd),
    .md_data          (md_data),
    .md_ready         (md_ready),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg),
    .we_onehot        (we_onehot),
    .md_pending       (md_pending)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;
  wr_t write_q[$];

  // Reference model: the pending md result and how many ALU grants it has lost
  logic        m_buf_v;
  logic [4:0]  m_buf_rd;
  logic [31:0] m_buf_data;
  int          m_losses;
  logic [4:0]  m_last_reg;
  logic [31:0] m_last_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_buf_v     = 1'b0;
    m_buf_rd    = '0;
    m_buf_data  = '0;
    m_losses    = 0;
    m_last_reg  = '0;
    m_last_data = '0;
    write_q.delete();
  endtask

  // One clock cycle: called at posedge+1, returns at the next posedge+1
  task automatic step(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                      input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                      output logic alu_acc, output logic md_acc);
    logic        forced, alu_go, md_out, md_in;
    logic [4:0]  wrd;
    logic [31:0] wd;
    alu_valid = av;
    alu_rd    = ard;
    alu_data  = ad;
    md_valid  = mv;
    md_rd     = mrd;
    md_data   = md;
    #1;
    forced = m_buf_v && (m_losses >= STARVE_LIMIT);
    alu_go = av && !forced;
    md_out = m_buf_v && !alu_go;
    md_in  = mv && (!m_buf_v || md_out);
    chk("alu_ready", {31'd0, alu_ready}, {31'd0, !forced});
    chk("md_ready", {31'd0, md_ready}, {31'd0, (!m_buf_v || md_out)});
    wrd = alu_go ? ard : m_buf_rd;
    wd  = alu_go ? ad : m_buf_data;
    if ((alu_go || md_out) && wrd != 5'd0) write_q.push_back('{rd: wrd, data: wd});
    @(posedge clock);
    if (alu_go || md_out) begin
      m_last_reg  = wrd;
      m_last_data = wd;
    end
    if (md_out) begin
      m_buf_v  = 1'b0;
      m_losses = 0;
    end else if (m_buf_v && alu_go) begin
      m_losses++;
    end
    if (md_in) begin
      m_buf_v    = 1'b1;
      m_buf_rd   = mrd;
      m_buf_data = md;
      m_losses   = 0;
    end
    #1;
    chk("md_pending", {31'd0, md_pending}, {31'd0, m_buf_v});
    alu_acc = alu_go;
    md_acc  = md_in;
  endtask

  task automatic idle(input int n);
    logic a, m;
    for (int i = 0; i < n; i++) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, a, m);
  endtask

  // Monitor: every enabled write must be the next one the model predicted
  always @(negedge clock) begin
    if (ctrl_reset_n) begin
      if (ctrl_writeEnable) begin
        if (write_q.size() == 0) begin
          chk("unexpected_write_reg", {27'd0, ctrl_writeReg}, 32'hFFFF_FFFF);
        end else begin
          wr_t e;
          e = write_q.pop_front();
          chk("write_reg", {27'd0, ctrl_writeReg}, {27'd0, e.rd});
          chk("write_data", data_writeReg, e.data);
          chk("write_onehot", we_onehot, 32'd1 << e.rd);
        end
      end else begin
        chk("idle_onehot", we_onehot, 32'd0);
      end
      chk("port_reg", {27'd0, ctrl_writeReg}, {27'd0, m_last_reg});
      chk("port_data", data_writeReg, m_last_data);
    end
  end

  logic        a_acc, m_acc;
  logic        a_v, m_v;
  logic [4:0]  a_rd, m_rd;
  logic [31:0] a_d, m_d;
  int          steps;

  initial begin
    alu_valid    = 1'b0;
    alu_rd       = '0;
    alu_data     = '0;
    md_valid     = 1'b0;
    md_rd        = '0;
    md_data      = '0;
    ctrl_reset_n = 1'b1;
    model_reset();
    #1 ctrl_reset_n = 1'b0;
    #1;
    chk("rst_we", {31'd0, ctrl_writeEnable}, 32'd0);
    chk("rst_reg", {27'd0, ctrl_writeReg}, 32'd0);
    chk("rst_data", data_writeReg, 32'd0);
    chk("rst_onehot", we_onehot, 32'd0);
    chk("rst_pending", {31'd0, md_pending}, 32'd0);
    chk("rst_alu_ready", {31'd0, alu_ready}, 32'd1);
    chk("rst_md_ready", {31'd0, md_ready}, 32'd1);
    repeat (2) @(posedge clock);
    #1 ctrl_reset_n = 1'b1;

    // Single ALU write, then an x0 write
    step(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0, a_acc, m_acc);
    chk("single_we", {31'd0, ctrl_writeEnable}, 32'd1);
    chk("single_onehot", we_onehot, 32'h0000_0020);
    step(1'b1, 5'd0, 32'h0000_1234, 1'b0, 5'd0, 32'd0, a_acc, m_acc);
    chk("single_we_off", {31'd0, ctrl_writeEnable}, 32'd0);
    idle(1);
    chk("x0_we", {31'd0, ctrl_writeEnable}, 32'd0);
    chk("x0_onehot", we_onehot, 32'd0);

    // md only
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd31, 32'd7, a_acc, m_acc);
    idle(1);
    chk("md_only_we", {31'd0, ctrl_writeEnable}, 32'd1);
    chk("md_only_onehot", we_onehot, 32'h8000_0000);
    idle(1);

    // Starvation: buffered md with ALU pressure on rd 1..6 costs exactly one stall
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd20, 32'hCAFE_0020, a_acc, m_acc);
    steps = 0;
    for (int r = 1; r <= 6; r++) begin
      a_acc = 1'b0;
      for (int t = 0; t < 20 && !a_acc; t++) begin
        step(1'b1, 5'(r), 32'h100 + 32'(r), 1'b0, 5'd0, 32'd0, a_acc, m_acc);
        steps++;
      end
    end
    chk("starve_steps", 32'(steps), 32'd7);
    idle(2);

    // Back-to-back md through the buffer
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 32'hAAAA_0010, a_acc, m_acc);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd11, 32'hBBBB_0011, a_acc, m_acc);
    chk("b2b_second_accepted", {31'd0, m_acc}, 32'd1);
    idle(3);

    // Reset mid-operation with the buffer full and three lost grants
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h9999_0009, a_acc, m_acc);
    for (int i = 0; i < 3; i++) step(1'b1, 5'd3, 32'h33 + 32'(i), 1'b0, 5'd0, 32'd0, a_acc, m_acc);
    alu_valid = 1'b1;
    md_valid  = 1'b1;
    md_rd     = 5'd12;
    #1 ctrl_reset_n = 1'b0;
    #1;
    model_reset();
    chk("midrst_pending", {31'd0, md_pending}, 32'd0);
    chk("midrst_we", {31'd0, ctrl_writeEnable}, 32'd0);
    chk("midrst_onehot", we_onehot, 32'd0);
    chk("midrst_alu_ready", {31'd0, alu_ready}, 32'd1);
    chk("midrst_md_ready", {31'd0, md_ready}, 32'd1);
    @(posedge clock);
    #1;
    chk("inrst_pending", {31'd0, md_pending}, 32'd0);
    chk("inrst_we", {31'd0, ctrl_writeEnable}, 32'd0);
    alu_valid = 1'b0;
    md_valid  = 1'b0;
    @(posedge clock);
    #1 ctrl_reset_n = 1'b1;
    idle(6);

    // Random traffic; a refused request is held stable until accepted
    a_v = 1'b0; a_rd = '0; a_d = '0; a_acc = 1'b1;
    m_v = 1'b0; m_rd = '0; m_d = '0; m_acc = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (!(a_v && !a_acc)) begin
        a_v  = ($urandom_range(0, 9) < 7);
        a_rd = 5'($urandom_range(0, 31));
        a_d  = $urandom;
      end
      if (!(m_v && !m_acc)) begin
        m_v  = ($urandom_range(0, 9) < 3);
        m_rd = 5'($urandom_range(0, 31));
        m_d  = $urandom;
      end
      step(a_v, a_rd, a_d, m_v, m_rd, m_d, a_acc, m_acc);
    end
    idle(8);
    @(negedge clock);
    #1;
    chk("queue_drained", 32'(write_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port between two requesters: the ALU writeback path (alu_*) and the multiply/divide unit (md_*).
- Arbitrates one write per cycle and registers the winning write onto ctrl_writeEnable, ctrl_writeReg and data_writeReg.
- Also drives a registered one-hot 32-bit write-enable vector that feeds the regfile's per-register enables directly.
- Holds one multdiv result in a one-entry buffer, and stops the ALU from starving it with a bounded wait counter.

Parameters:
STARVE_LIMIT, 4, max consecutive cycles the buffered md result loses to the ALU before it is forced to win (0 = md always wins).
CNT_W, 3, width of the starvation counter; must hold STARVE_LIMIT.

Ports:
clock  input  1  single clock; all state updates on the rising edge
ctrl_reset_n  input  1  asynchronous, active-low reset
alu_valid  input  1  ALU write request
alu_rd  input  5  ALU destination register
alu_data  input  32  ALU write data
alu_ready  output  1  ALU request accepted this cycle (combinational)
md_valid  input  1  multdiv result valid
md_rd  input  5  multdiv destination register
md_data  input  32  multdiv result
md_ready  output  1  multdiv result accepted into the buffer (combinational)
ctrl_writeEnable  output  1  registered regfile write enable
ctrl_writeReg  output  5  registered destination register
data_writeReg  output  32  registered write data
we_onehot  output  32  registered one-hot enable; bit k set iff ctrl_writeEnable and ctrl_writeReg==k
md_pending  output  1  buffer full (status)

Behaviour:
- Handshake: a transfer occurs when valid&&ready. The requester holds rd/data stable while valid&&!ready.
- md buffer (buf_full, buf_rd, buf_data):
  - md_ready = !buf_full || drain, where drain = the buffer is granted this cycle.
  - An md transfer loads the buffer on the next edge.
  - Drain and load in the same cycle leave buf_full=1 with the new contents.
- Arbitration, evaluated each cycle:
  - force_md = buf_full && (wait_cnt >= STARVE_LIMIT).
  - alu_ready = !force_md.
  - drain = buf_full && (force_md || !alu_valid).
  - ALU wins if alu_valid && alu_ready, otherwise the buffer wins if buf_full.
- Starvation counter wait_cnt:
  - Clears when the buffer drains or is empty.
  - Otherwise increments (saturating) each cycle buf_full && the ALU is granted.
  - Consequence: the md result waits at most STARVE_LIMIT ALU grants.
- Output stage, one-cycle latency from the grant edge:
  - ctrl_writeReg and data_writeReg load the winner's rd/data.
  - ctrl_writeEnable = 1 iff there was a winner and winner rd != 0.
  - we_onehot = one-hot of rd, gated by the same condition.
  - With no winner, ctrl_writeEnable=0 and we_onehot=0; ctrl_writeReg and data_writeReg hold their last value.
- Register 0: requests with rd=0 complete the handshake normally, but produce no write (enable and one-hot both stay 0).
- Ordering hazards: if the ALU and the buffered md result target the same register, the order of writes follows grant order. Program-order hazard avoidance is the issuing pipeline's responsibility.
- Reset, asynchronous and effective immediately:
  - buf_full=0, wait_cnt=0, ctrl_writeEnable=0, ctrl_writeReg=0, data_writeReg=0, we_onehot=0, md_pending=0.
  - A buffered result is discarded on reset mid-operation.
  - While ctrl_reset_n=0: alu_ready=1 and md_ready=1, but no transfer has any effect.
- Invariant: at most one bit of we_onehot is set in any cycle, and it matches ctrl_writeReg whenever ctrl_writeEnable=1.

Test Plan:
- Reset then single ALU write: alu_valid=1, rd=5, data=0xDEADBEEF for one cycle → alu_ready=1. Next cycle ctrl_writeEnable=1, ctrl_writeReg=5, data_writeReg=0xDEADBEEF, we_onehot=0x00000020. The cycle after, all enables are 0.
- Register 0 write: alu rd=0, data=0x1234 → handshake completes, ctrl_writeEnable=0 and we_onehot=0 on the following cycle.
- md only: md_valid=1, rd=31, data=7 → md_ready=1, md_pending=1 next cycle, buffer drains that cycle. ctrl_writeEnable=1, ctrl_writeReg=31, we_onehot=0x80000000 two cycles after the request.
- Starvation with STARVE_LIMIT=4: md buffered while alu_valid stays high with rd=1..6 → the ALU wins 4 grants (wait_cnt 0→4), then alu_ready=0 for one cycle and the md write issues. The ALU resumes on the next cycle; no ALU request is lost.
- Back-to-back md: buffer full and draining while a second md_valid is asserted → md_ready=1 in the drain cycle, md_pending stays 1, and both results reach the write port on consecutive grants in order.
- Reset mid-operation: buffer full and wait_cnt=3, assert ctrl_reset_n=0 asynchronously mid-cycle → md_pending, ctrl_writeEnable and we_onehot go to 0 immediately. After release, the buffered result is never written.
